register_file_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined core. It succeeds the single-write, two-read register file. It adds:
- configurable width, depth and read-port count;
- two write ports with defined priority;
- synchronous clear;
- a per-register busy scoreboard that decode uses for RAW-hazard stalls.

It sits between decode (reads, reservations) and writeback (ALU and load results).

---
 rtl/register_file_mp_pkg.sv | 25 ++
 rtl/regfile_read_port.sv | 72 +++++++
 rtl/register_file_mp.sv | 103 ++++++++++
 tb/tb_register_file_mp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp_pkg
//  Purpose  : Shared constants for the multi-port register file: default
//             geometry, the hardwired-zero register address and the
//             write-port priority selector.
//  Ports    : none (package)
//  Config   : REGFILE_BYPASS_EN (consumed by regfile_read_port)
//  Revision : 1.0  initial release
// ============================================================================
package register_file_mp_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_READ = 2;

  // Architectural zero register: never written, never busy, always reads 0.
  localparam int unsigned REG_ZERO = 0;

  // On a same-address collision the load port (B) overwrites the ALU port (A).
  localparam bit WR_PRIO_B_OVER_A = 1'b1;

endpackage : register_file_mp_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_port
//  Purpose  : One combinational read port: storage mux, x0 masking and,
//             when REGFILE_BYPASS_EN is defined, same-cycle write forwarding.
//  Ports    : regs_i / busy_i       flattened storage and busy scoreboard
//             addr_i                 read address
//             wa_* / wb_*            write ports (bypass build only)
//             data_o / busy_o        read data and busy flag
//  Config   : REGFILE_BYPASS_EN
//  Revision : 1.0  initial release
// ============================================================================
module regfile_read_port
  import register_file_mp_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic [NUM_REGS-1:0][XLEN-1:0] regs_i,
  input  logic [NUM_REGS-1:0]           busy_i,
  input  logic [ADDR_W-1:0]             addr_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                          wa_en_i,
  input  logic [ADDR_W-1:0]             wa_addr_i,
  input  logic [XLEN-1:0]               wa_data_i,
  input  logic                          wb_en_i,
  input  logic [ADDR_W-1:0]             wb_addr_i,
  input  logic [XLEN-1:0]               wb_data_i,
`endif
  output logic [XLEN-1:0]               data_o,
  output logic                          busy_o
);

  logic w_is_zero;
  assign w_is_zero = (addr_i == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;
  assign w_hit_a = wa_en_i && (wa_addr_i == addr_i) && !w_is_zero;
  assign w_hit_b = wb_en_i && (wb_addr_i == addr_i) && !w_is_zero;
`endif

  always_comb begin
    data_o = w_is_zero ? '0 : regs_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // Forward in the same order the storage resolves a collision, and report
    // not-busy because the producer is completing this very cycle.
    if (WR_PRIO_B_OVER_A) begin
      if (w_hit_b) begin
        data_o = wb_data_i;
        busy_o = 1'b0;
      end else if (w_hit_a) begin
        data_o = wa_data_i;
        busy_o = 1'b0;
      end
    end else begin
      if (w_hit_a) begin
        data_o = wa_data_i;
        busy_o = 1'b0;
      end else if (w_hit_b) begin
        data_o = wb_data_i;
        busy_o = 1'b0;
      end
    end
`endif
  end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp
//  Purpose  : Multi-port integer register file with two write ports, a
//             per-register busy scoreboard and NUM_READ combinational reads.
//  Ports    : clk_i, reset_i                 clock, sync active-high reset
//             read_addr_i / read_data_o / read_busy_o   packed read ports
//             wa_*_i                         write port A (ALU writeback)
//             wb_*_i                         write port B (load writeback)
//             rsv_en_i / rsv_addr_i          mark a register busy
//             flush_i                        clear every busy bit
//  Config   : REGFILE_BYPASS_EN enables same-cycle write forwarding
//  Revision : 1.0  initial release
// ============================================================================
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_READ = DEF_NUM_READ
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_READ*ADDR_W-1:0] read_addr_i,
  output logic [NUM_READ*XLEN-1:0]   read_data_o,
  output logic [NUM_READ-1:0]        read_busy_o,
  input  logic                       wa_en_i,
  input  logic [ADDR_W-1:0]          wa_addr_i,
  input  logic [XLEN-1:0]            wa_data_i,
  input  logic                       wb_en_i,
  input  logic [ADDR_W-1:0]          wb_addr_i,
  input  logic [XLEN-1:0]            wb_data_i,
  input  logic                       rsv_en_i,
  input  logic [ADDR_W-1:0]          rsv_addr_i,
  input  logic                       flush_i
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           busy_q, busy_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != REG_ZERO) begin
        if (WR_PRIO_B_OVER_A) begin
          if (wb_en_i && (wb_addr_i == ADDR_W'(i)))      regs_d[i] = wb_data_i;
          else if (wa_en_i && (wa_addr_i == ADDR_W'(i))) regs_d[i] = wa_data_i;
        end else begin
          if (wa_en_i && (wa_addr_i == ADDR_W'(i)))      regs_d[i] = wa_data_i;
          else if (wb_en_i && (wb_addr_i == ADDR_W'(i))) regs_d[i] = wb_data_i;
        end
        // Completion clears first so a same-cycle reservation (new producer)
        // takes precedence below.
        if ((wa_en_i && (wa_addr_i == ADDR_W'(i))) ||
            (wb_en_i && (wb_addr_i == ADDR_W'(i))))
          busy_d[i] = 1'b0;
        if (rsv_en_i && (rsv_addr_i == ADDR_W'(i)))
          busy_d[i] = 1'b1;
      end
    end
    regs_d[REG_ZERO] = '0;
    busy_d[REG_ZERO] = 1'b0;
    // Flush drops every outstanding reservation but leaves data writes intact.
    if (flush_i)
      busy_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_read_port
    regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_read_port (
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .addr_i    (read_addr_i[g*ADDR_W +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
      .wa_en_i   (wa_en_i),
      .wa_addr_i (wa_addr_i),
      .wa_data_i (wa_data_i),
      .wb_en_i   (wb_en_i),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
`endif
      .data_o    (read_data_o[g*XLEN +: XLEN]),
      .busy_o    (read_busy_o[g])
    );
  end

endmodule : register_file_mp
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_mp
//  Purpose  : Self-checking bench for register_file_mp (2 read ports,
//             32 x 32-bit). Expectations adapt to REGFILE_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_file_mp;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   read_addr;
  logic [NRD*XLEN-1:0] read_data;
  logic [NRD-1:0]      read_busy;
  logic                wa_en, wb_en, rsv_en, flush;
  logic [AW-1:0]       wa_addr, wb_addr, rsv_addr;
  logic [XLEN-1:0]     wa_data, wb_data;

  always #5 clk = ~clk;

  register_file_mp #(
    .XLEN(XLEN), .NUM_REGS(NR), .ADDR_W(AW), .NUM_READ(NRD)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .read_addr_i (read_addr),
    .read_data_o (read_data),
    .read_busy_o (read_busy),
    .wa_en_i     (wa_en),
    .wa_addr_i   (wa_addr),
    .wa_data_i   (wa_data),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .rsv_en_i    (rsv_en),
    .rsv_addr_i  (rsv_addr),
    .flush_i     (flush)
  );

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        busy;
    string       tag;
  } exp_t;

  typedef struct {
    logic        wa_en; logic [4:0] wa_addr; logic [31:0] wa_data;
    logic        wb_en; logic [4:0] wb_addr; logic [31:0] wb_data;
    logic        rsv_en; logic [4:0] rsv_addr; logic flush;
    logic [4:0]  r0; logic [31:0] d0; logic b0;
    logic [4:0]  r1; logic [31:0] d1; logic b1;
  } vec_t;

  exp_t sb[$];
  vec_t vt[16];
  int   checks   = 0;
  int   failures = 0;

  task automatic idle();
    reset = 1'b0; flush = 1'b0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Advance past one rising edge and return all controls to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_read(input int port, input logic [4:0] a,
                          input logic [31:0] d, input logic b, input string tag);
    exp_t e;
    read_addr[port*AW +: AW] = a;
    e.port = port; e.addr = a; e.data = d; e.busy = b; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_reads();
    exp_t        e;
    logic [31:0] gd;
    logic        gb;
    #2;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      gd = read_data[e.port*XLEN +: XLEN];
      gb = read_busy[e.port];
      checks++;
      if (gd !== e.data || gb !== e.busy) begin
        failures++;
        $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.tag, e.port, e.addr, gd, gb, e.data, e.busy);
      end
    end
  endtask

  initial begin
    idle();
    read_addr = '0;

    // ---------------- vector table ----------------
    //        wa_en addr  data          wb_en addr  data          rsv  addr  fl   r0    d0            b0    r1    d1            b1
    vt[0]  = '{1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd1, 32'h0,        1'b0, 5'd2, 32'h0,        1'b0};
    vt[1]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1,5'd7, 32'h11,       1'b1,5'd7, 32'h22,       1'b0,5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd6, 32'h0,        1'b0};
    vt[3]  = '{1'b1,5'd0, 32'hFFFFFFFF, 1'b0,5'd0, 32'h0,        1'b1,5'd0, 1'b0, 5'd7, 32'h22,       1'b0, 5'd0, 32'h0,        1'b0};
    vt[4]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h22,       1'b0};
    vt[5]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd9, 1'b0, 5'd9, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
    vt[6]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd9, 32'h0,        1'b1, 5'd8, 32'h0,        1'b0};
    vt[7]  = '{1'b0,5'd0, 32'h0,        1'b1,5'd9, 32'hCAFE0009, 1'b1,5'd9, 1'b0, 5'd3, 32'h0,        1'b0, 5'd4, 32'h0,        1'b0};
    vt[8]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd9, 32'hCAFE0009, 1'b1, 5'd7, 32'h22,       1'b0};
    vt[9]  = '{1'b1,5'd9, 32'h12345678, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, 32'h22,       1'b0};
    vt[10] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd9, 32'h12345678, 1'b0, 5'd31,32'h0,        1'b0};
    vt[11] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b0, 5'd3, 32'h0,        1'b0, 5'd4, 32'h0,        1'b0};
    vt[12] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd4, 1'b0, 5'd3, 32'h0,        1'b1, 5'd4, 32'h0,        1'b0};
    vt[13] = '{1'b1,5'd20,32'hA5A5A5A5, 1'b0,5'd0, 32'h0,        1'b1,5'd6, 1'b1, 5'd3, 32'h0,        1'b1, 5'd4, 32'h0,        1'b1};
    vt[14] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd3, 32'h0,        1'b0, 5'd4, 32'h0,        1'b0};
    vt[15] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 5'd6, 32'h0,        1'b0, 5'd20,32'hA5A5A5A5, 1'b0};

    // ---------------- reset, then sweep every address ----------------
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    for (int i = 0; i < NR; i++) begin
      set_read(0, 5'(i),      32'h0, 1'b0, "reset_p0");
      set_read(1, 5'(NR-1-i), 32'h0, 1'b0, "reset_p1");
      check_reads();
      step();
    end

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < 16; v++) begin
      wa_en = vt[v].wa_en; wa_addr = vt[v].wa_addr; wa_data = vt[v].wa_data;
      wb_en = vt[v].wb_en; wb_addr = vt[v].wb_addr; wb_data = vt[v].wb_data;
      rsv_en = vt[v].rsv_en; rsv_addr = vt[v].rsv_addr; flush = vt[v].flush;
      set_read(0, vt[v].r0, vt[v].d0, vt[v].b0, $sformatf("vec%0d_p0", v));
      set_read(1, vt[v].r1, vt[v].d1, vt[v].b1, $sformatf("vec%0d_p1", v));
      check_reads();
      step();
    end

    // ---------------- same-cycle forwarding of a reserved register ----------------
    rsv_en = 1'b1; rsv_addr = 5'd13;
    step();
    wa_en = 1'b1; wa_addr = 5'd13; wa_data = 32'h13131313;
    set_read(0, 5'd13, BYP ? 32'h13131313 : 32'h0, BYP ? 1'b0 : 1'b1, "byp_same_cycle");
    set_read(1, 5'd5, 32'hDEADBEEF, 1'b0, "byp_other_addr");
    check_reads();
    step();
    set_read(0, 5'd13, 32'h13131313, 1'b0, "write_then_read");
    check_reads();

    // ---------------- A/B collision seen through the forwarding path ----------------
    wa_en = 1'b1; wa_addr = 5'd14; wa_data = 32'h1;
    wb_en = 1'b1; wb_addr = 5'd14; wb_data = 32'h2;
    set_read(0, 5'd14, BYP ? 32'h2 : 32'h0, 1'b0, "byp_b_priority");
    check_reads();
    step();
    set_read(0, 5'd14, 32'h2, 1'b0, "collision_stored");
    check_reads();

    // ---------------- x0 with both writes and a reservation ----------------
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_read(0, 5'd0, 32'h0, 1'b0, "x0_no_forward");
    check_reads();
    step();
    set_read(1, 5'd0, 32'h0, 1'b0, "x0_after");
    check_reads();

    // ---------------- reset in the middle of traffic ----------------
    wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 5'd15;
    step();
    set_read(0, 5'd12, 32'h77, 1'b0, "pre_reset_data");
    set_read(1, 5'd15, 32'h0,  1'b1, "pre_reset_busy");
    check_reads();
    reset = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd16;
    step();
    set_read(0, 5'd12, 32'h0, 1'b0, "reset_drops_write");
    set_read(1, 5'd15, 32'h0, 1'b0, "reset_clears_busy");
    check_reads();
    step();
    set_read(0, 5'd16, 32'h0, 1'b0, "reset_drops_rsv");
    set_read(1, 5'd20, 32'h0, 1'b0, "reset_clears_data");
    check_reads();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus thread ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_register_file_mp
`default_nettype wire
